// File: rtl/seg_scan_driver.sv
// seg_scan_driver: six-digit multiplexed 7-segment display driver.
// A serial shift-add-3 converter turns the binary input into BCD and commits
// digits, sign and decimal points to the display registers in one step.
// The scan side then walks the six digit slots and drives the active-low
// select and segment lines.
module seg_scan_driver #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        en,
  input  logic        sign,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  localparam int          PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [19:0] MAX_VAL = 20'd999_999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  conv_state_t state;

  // Snapshot of the raw inputs behind the current display contents.
  // It holds the unclamped value, so an over-range input is converted only once.
  logic [19:0] snap_data;
  logic        snap_sign;
  logic [5:0]  snap_point;

  // Inputs captured when a conversion starts.
  logic [19:0] cap_data;
  logic        cap_sign;
  logic [5:0]  cap_point;

  // Conversion datapath.
  logic [19:0] bin_sr;
  logic [23:0] bcd_sr;
  logic [23:0] bcd_adj;
  logic [43:0] conv_next;
  logic [4:0]  bit_cnt;

  // Committed display registers.
  logic [23:0] disp_bcd;
  logic        disp_sign;
  logic [5:0]  disp_point;

  // Scan datapath.
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic          wrap;
  logic [5:0]    blank;
  logic [5:0]    minus;
  logic [3:0]    cur_digit;
  logic [6:0]    glyph;
  logic [7:0]    led_next;

  // Add 3 to every BCD nibble of 5 or more, then shift the BCD/binary pair left.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int k = 0; k < 6; k++) begin
      if (bcd_sr[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
    end
    conv_next = {bcd_adj, bin_sr} << 1;
  end

  // Converter FSM: detect an input change, convert one bit per cycle, commit atomically.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap_data  <= '0;
      snap_sign  <= 1'b0;
      snap_point <= '0;
      cap_data   <= '0;
      cap_sign   <= 1'b0;
      cap_point  <= '0;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      bit_cnt    <= '0;
      disp_bcd   <= '0;
      disp_sign  <= 1'b0;
      disp_point <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ({data, sign, point} != {snap_data, snap_sign, snap_point}) begin
            cap_data  <= data;
            cap_sign  <= sign;
            cap_point <= point;
            bin_sr    <= (data > MAX_VAL) ? MAX_VAL : data;
            bcd_sr    <= '0;
            bit_cnt   <= '0;
            state     <= CONV;
          end
        end
        CONV: begin
          bcd_sr  <= conv_next[43:20];
          bin_sr  <= conv_next[19:0];
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd19) state <= DONE;
        end
        DONE: begin
          disp_bcd   <= bcd_sr;
          disp_sign  <= cap_sign;
          disp_point <= cap_point;
          snap_data  <= cap_data;
          snap_sign  <= cap_sign;
          snap_point <= cap_point;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit index that takes effect at the next edge.
  always_comb begin
    wrap     = (presc == PW'(SCAN_DIV - 1));
    idx_next = idx;
    if (wrap) idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  end

  // Leading-zero blanking from the top down; a set decimal point keeps its digit lit.
  // The minus sign takes the lowest blanked slot, so it disappears when nothing is blank.
  always_comb begin
    blank    = '0;
    blank[5] = (disp_bcd[23:20] == 4'd0) && !disp_point[5];
    for (int i = 4; i >= 1; i--) begin
      blank[i] = blank[i+1] && (disp_bcd[4*i +: 4] == 4'd0) && !disp_point[i];
    end
    minus = '0;
    for (int i = 1; i < 6; i++) begin
      minus[i] = disp_sign && blank[i] && !blank[i-1];
    end
  end

  // Segment pattern for the digit selected at the next edge.
  always_comb begin
    cur_digit = disp_bcd[{idx_next, 2'b00} +: 4];
    case (cur_digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
    if (blank[idx_next]) glyph = minus[idx_next] ? 7'h3F : 7'h7F;
    led_next = {~(disp_point[idx_next] & ~blank[idx_next]), glyph};
  end

  // Scan prescaler, digit index and registered select/segment outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      idx     <= '0;
      seg_sel <= 6'h3F;
      seg_led <= 8'hFF;
    end else begin
      presc   <= wrap ? '0 : presc + PW'(1);
      idx     <= idx_next;
      seg_sel <= en ? ~(6'b000001 << idx_next) : 6'h3F;
      seg_led <= en ? led_next : 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: randomized and directed stimulus checked every
// cycle against a behavioural model (arithmetic digit extraction, commit
// scheduled by cycle count, scan slot derived from the cycle count).
module tb_seg_scan_driver;

  localparam int SCAN_DIV = 4;
  // Capture cycle + 20 conversion cycles + commit cycle: the display
  // registers change on the 21st edge after the capturing edge.
  localparam int LAT = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] data;
  logic [5:0]  point;
  logic        en;
  logic        sign;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  int vectors     = 0;
  int miscompares = 0;

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .point   (point),
    .en      (en),
    .sign    (sign),
    .seg_sel (seg_sel),
    .seg_led (seg_led)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural model state
  int          m_n;
  bit          m_busy;
  int          m_commit_at;
  int          m_cap_val;
  logic [19:0] m_cap_raw;
  bit          m_cap_sign;
  logic [5:0]  m_cap_point;
  logic [19:0] m_snap_data;
  bit          m_snap_sign;
  logic [5:0]  m_snap_point;
  int          m_val;
  bit          m_sign;
  logic [5:0]  m_point;

  // Scoreboard of expected {seg_sel, seg_led}, one entry per clock
  logic [13:0] exp_q[$];

  function automatic logic [7:0] digit_code(int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  function automatic logic [7:0] model_led(int val, bit sgn, logic [5:0] pt, int slot);
    int d[6];
    bit blank[7];
    int v;
    int lowest;
    v = val;
    for (int i = 0; i < 6; i++) begin
      d[i] = v % 10;
      v = v / 10;
    end
    blank[6] = 1'b1;
    for (int i = 5; i >= 1; i--) blank[i] = blank[i+1] && (d[i] == 0) && !pt[i];
    blank[0] = 1'b0;
    lowest = -1;
    for (int i = 1; i < 6; i++) if (blank[i] && lowest < 0) lowest = i;
    if (blank[slot]) return (sgn && slot == lowest) ? 8'hBF : 8'hFF;
    return pt[slot] ? (digit_code(d[slot]) & 8'h7F) : digit_code(d[slot]);
  endfunction

  // Advance one clock: update the model from the sampled inputs and queue the
  // expected outputs that appear after this edge.
  task automatic tick();
    logic [5:0] esel;
    logic [7:0] eled;
    int slot;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_busy = 0; m_commit_at = 0;
      m_snap_data = '0; m_snap_sign = 0; m_snap_point = '0;
      m_val = 0; m_sign = 0; m_point = '0;
      esel = 6'h3F; eled = 8'hFF;
    end else begin
      m_n++;
      slot = (m_n / SCAN_DIV) % 6;
      if (en) begin
        esel = ~(6'b000001 << slot);
        eled = model_led(m_val, m_sign, m_point, slot);
      end else begin
        esel = 6'h3F; eled = 8'hFF;
      end
      if (m_busy) begin
        if (m_n == m_commit_at) begin
          m_val = m_cap_val; m_sign = m_cap_sign; m_point = m_cap_point;
          m_snap_data = m_cap_raw; m_snap_sign = m_cap_sign; m_snap_point = m_cap_point;
          m_busy = 0;
        end
      end else if ({data, sign, point} != {m_snap_data, m_snap_sign, m_snap_point}) begin
        m_cap_raw = data; m_cap_sign = sign; m_cap_point = point;
        m_cap_val = (int'(data) > 999999) ? 999999 : int'(data);
        m_busy = 1; m_commit_at = m_n + LAT;
      end
    end
    exp_q.push_back({esel, eled});
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    logic [7:0] seen[6];
    rst = 1; en = 1; data = '0; point = '0; sign = 0;
    tick();
    exp = exp_q.pop_front();
    vectors++;
    if ({seg_sel, seg_led} !== 14'h3FFF) begin
      miscompares++;
      $display("FAIL reset_out got %h/%h want 3f/ff", seg_sel, seg_led);
    end
    tick();
    exp = exp_q.pop_front();
    rst = 0;
    for (int i = 0; i < 6; i++) seen[i] = 8'h00;
    for (int c = 0; c < 30; c++) begin
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if ({seg_sel, seg_led} !== exp) begin
        miscompares++;
        $display("FAIL reset_scan cyc %0d got %h/%h want %h/%h", c, seg_sel, seg_led, exp[13:8], exp[7:0]);
      end
      for (int i = 0; i < 6; i++) if (seg_sel == ~(6'b000001 << i)) seen[i] = seg_led;
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (seen[i] !== ((i == 0) ? 8'hC0 : 8'hFF)) begin
        miscompares++;
        $display("FAIL reset_digit%0d got %h want %h", i, seen[i], (i == 0) ? 8'hC0 : 8'hFF);
      end
    end
  endtask

  // Apply a value, let it convert, then check one full scan against fixed codes.
  task automatic test_display(string name, logic [19:0] d, logic s, logic [5:0] p, logic [47:0] want);
    logic [13:0] exp;
    logic [7:0] seen[6];
    data = d; sign = s; point = p; en = 1;
    for (int i = 0; i < 6; i++) seen[i] = 8'h00;
    for (int c = 0; c < 48; c++) begin
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if ({seg_sel, seg_led} !== exp) begin
        miscompares++;
        $display("FAIL %s cyc %0d got %h/%h want %h/%h", name, c, seg_sel, seg_led, exp[13:8], exp[7:0]);
      end
      if (c >= 24) for (int i = 0; i < 6; i++) if (seg_sel == ~(6'b000001 << i)) seen[i] = seg_led;
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (seen[i] !== want[8*i +: 8]) begin
        miscompares++;
        $display("FAIL %s digit%0d got %h want %h", name, i, seen[i], want[8*i +: 8]);
      end
    end
  endtask

  task automatic wait_idle(string name);
    logic [13:0] exp;
    for (int c = 0; c < 60 && m_busy; c++) begin
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if ({seg_sel, seg_led} !== exp) begin
        miscompares++;
        $display("FAIL %s_idle cyc %0d got %h/%h want %h/%h", name, c, seg_sel, seg_led, exp[13:8], exp[7:0]);
      end
    end
    vectors++;
    if (m_busy) begin
      miscompares++;
      $display("FAIL %s_idle_timeout got busy want idle", name);
    end
  endtask

  task automatic test_change_during_conv();
    logic [13:0] exp;
    wait_idle("chg");
    data = 20'd7; sign = 0; point = '0; en = 1;
    tick();
    exp = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if ({seg_sel, seg_led} !== exp) begin
        miscompares++;
        $display("FAIL chg_pre cyc %0d got %h/%h want %h/%h", c, seg_sel, seg_led, exp[13:8], exp[7:0]);
      end
    end
    data = 20'd8;
    for (int c = 0; c < 80; c++) begin
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if ({seg_sel, seg_led} !== exp) begin
        miscompares++;
        $display("FAIL chg_post cyc %0d got %h/%h want %h/%h", c, seg_sel, seg_led, exp[13:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [13:0] exp;
    wait_idle("rstconv");
    data = 20'd555555; sign = 0; point = '0; en = 1;
    for (int c = 0; c < 11; c++) begin
      tick();
      exp = exp_q.pop_front();
    end
    rst = 1;
    tick();
    exp = exp_q.pop_front();
    vectors++;
    if ({seg_sel, seg_led} !== 14'h3FFF) begin
      miscompares++;
      $display("FAIL rstconv_out got %h/%h want 3f/ff", seg_sel, seg_led);
    end
    rst = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if ({seg_sel, seg_led} !== exp) begin
        miscompares++;
        $display("FAIL rstconv cyc %0d got %h/%h want %h/%h", c, seg_sel, seg_led, exp[13:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_enable_toggle();
    logic [13:0] exp;
    en = 1;
    for (int c = 0; c < 23; c++) begin
      if (c == 7) en = 0;
      if (c == 16) en = 1;
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if ({seg_sel, seg_led} !== exp) begin
        miscompares++;
        $display("FAIL en_toggle cyc %0d got %h/%h want %h/%h", c, seg_sel, seg_led, exp[13:8], exp[7:0]);
      end
      if (c >= 7 && c < 16) begin
        vectors++;
        if ({seg_sel, seg_led} !== 14'h3FFF) begin
          miscompares++;
          $display("FAIL en_dark cyc %0d got %h/%h want 3f/ff", c, seg_sel, seg_led);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] exp;
    int hold;
    for (int seg = 0; seg < 50; seg++) begin
      data  = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 999999)) : 20'($urandom);
      if ($urandom_range(0, 3) == 0) data = 20'($urandom_range(0, 99));
      sign  = 1'($urandom_range(0, 1));
      point = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      en    = ($urandom_range(0, 9) != 0);
      rst   = ($urandom_range(0, 14) == 0);
      hold  = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        tick();
        rst = 0;
        exp = exp_q.pop_front();
        vectors++;
        if ({seg_sel, seg_led} !== exp) begin
          miscompares++;
          $display("FAIL random seg %0d cyc %0d got %h/%h want %h/%h", seg, c, seg_sel, seg_led, exp[13:8], exp[7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_display("basic",   20'd123456, 1'b0, 6'b000000, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
    test_display("sign24",  20'd24,     1'b1, 6'b000010, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h24, 8'h99});
    test_display("sign42",  20'd42,     1'b1, 6'b000010, {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h19, 8'hA4});
    test_display("nosign",  20'd654321, 1'b1, 6'b000000, {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9});
    test_display("clamp",   20'd1000000, 1'b0, 6'b000000, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});
    test_display("zero",    20'd0,      1'b0, 6'b000000, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    test_display("ptzero",  20'd0,      1'b0, 6'b100000, {8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
    test_change_during_conv();
    test_reset_mid_conv();
    test_enable_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
